data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 18 +
 rtl/dmr_storage.sv | 39 +++
 rtl/data_mem_responder.sv | 132 +++++++++++++
 tb/tb_data_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder.
// Holds the FSM state encoding, the data and address widths and the legal LATENCY range.
package data_mem_responder_pkg;

  localparam int unsigned DataWidth  = 16;
  localparam int unsigned AddrWidth  = 16;
  localparam int unsigned LatencyMin = 1;
  localparam int unsigned LatencyMax = 8;
  // Wide enough for LATENCY-1 at the top of the legal range.
  localparam int unsigned CntWidth   = $clog2(LatencyMax);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/dmr_storage.sv
// Data word storage for the memory responder: Depth x DataWidth array with a synchronous write
// and a registered read.
// Ports:
//   clk_i   - clock
//   we_i    - write enable; wdata_i is written to addr_i on the rising edge
//   re_i    - read enable; mem[addr_i] is captured into rdata_o on the rising edge
//   addr_i  - word index (caller guarantees it is in range when an enable is set)
//   wdata_i - write data
//   rdata_o - registered read data, held until the next read
// There is no reset: contents survive a responder reset.
module dmr_storage
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned Depth    = 256,
  parameter int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [IdxWidth-1:0]  addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder. Accepts one load/store at a time, waits LATENCY cycles,
// performs the access against dmr_storage and presents the result until the pipeline takes it.
// Ports:
//   CLK, RST              - clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake (ready only while idle)
//   req_we                - 1 = store, 0 = load
//   req_addr, req_wdata   - word address and store data, latched on acceptance
//   resp_valid/resp_ready - response handshake
//   resp_rdata            - load data; 0 for stores and out-of-range accesses
//   resp_err              - address was >= DEPTH
//   busy                  - a request is outstanding (pipeline stall)
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DataWidth-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 busy
);

  localparam int unsigned         IdxWidth   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntWidth-1:0] CntInit    = CntWidth'(LATENCY - 1);
  localparam logic [AddrWidth:0]  DepthLimit = (AddrWidth + 1)'(DEPTH);

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;

  logic                   in_range;
  logic                   mem_we, mem_re;
  logic [DataWidth-1:0]   mem_rdata;

  assign in_range = ({1'b0, addr_q} < DepthLimit);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          err_d   = 1'b0;
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          // Access happens on the edge that enters StResp; out-of-range touches nothing.
          mem_we  = we_q & in_range;
          mem_re  = ~we_q & in_range;
          err_d   = ~in_range;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Read register is not reset, so gate the data here to keep it 0 outside a valid load.
  assign resp_err   = (state_q == StResp) & err_q;
  assign resp_rdata = ((state_q == StResp) && !we_q && !err_q) ? mem_rdata : '0;

  dmr_storage #(
    .Depth    (DEPTH),
    .IdxWidth (IdxWidth)
  ) u_storage (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_q[IdxWidth-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: table vectors, hand-written corner sequences and
// randomized transactions checked against an array model of the storage.
module tb_data_mem_responder;

  localparam int unsigned Depth = 256;
  localparam int          Lat   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, busy;
  logic [15:0] req_addr, req_wdata, resp_rdata;
  logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_ready1, resp_err1, busy1;
  logic [15:0] req_addr1, req_wdata1, resp_rdata1;

  int checks = 0;
  int errors = 0;
  logic [15:0] model [Depth];

  data_mem_responder #(.DEPTH(Depth), .LATENCY(Lat)) dut (
    .CLK        (clk),
    .RST        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  data_mem_responder #(.DEPTH(Depth), .LATENCY(1)) dut1 (
    .CLK        (clk),
    .RST        (rst),
    .req_valid  (req_valid1),
    .req_ready  (req_ready1),
    .req_we     (req_we1),
    .req_addr   (req_addr1),
    .req_wdata  (req_wdata1),
    .resp_valid (resp_valid1),
    .resp_ready (resp_ready1),
    .resp_rdata (resp_rdata1),
    .resp_err   (resp_err1),
    .busy       (busy1)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          delay;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Junk on the request inputs while busy must not disturb anything.
  task automatic scramble();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int delay, input logic exp_err, input logic [15:0] exp_rdata);
    int edges;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = 1'b0;
    @(posedge clk);
    #1 scramble();
    @(negedge clk);
    check("busy_after_accept", 32'({busy, req_ready}), 32'b10);
    edges = 0;
    while (!resp_valid && edges < 16) begin
      @(posedge clk);
      edges++;
      #1 scramble();
      @(negedge clk);
    end
    check("latency", 32'(edges), 32'(Lat));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
    for (int i = 0; i < delay; i++) begin
      @(posedge clk);
      #1 scramble();
      @(negedge clk);
      check("resp_hold", 32'({resp_valid, busy, resp_err, resp_rdata}),
            32'({2'b11, exp_err, exp_rdata}));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("after_handshake", 32'({resp_valid, req_ready, busy}), 32'b010);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  task automatic model_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input int delay);
    logic        err;
    logic [15:0] exp;
    err = (32'(addr) >= Depth);
    exp = (we || err) ? 16'h0 : model[addr[7:0]];
    do_txn(we, addr, wdata, delay, err, exp);
    if (we && !err) model[addr[7:0]] = wdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0; req_we  = 1'b0; req_addr  = '0; req_wdata  = '0; resp_ready  = 1'b0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; resp_ready1 = 1'b0;

    vecs[0]  = '{1'b1, 16'd5,     16'h1234, 0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 16'd5,     16'h0000, 0, 1'b0, 16'h1234};
    vecs[2]  = '{1'b1, 16'd44,    16'h4444, 0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 16'd300,   16'h0000, 0, 1'b1, 16'h0000};
    vecs[4]  = '{1'b0, 16'd44,    16'h0000, 1, 1'b0, 16'h4444};
    vecs[5]  = '{1'b1, 16'd300,   16'hDEAD, 2, 1'b1, 16'h0000};
    vecs[6]  = '{1'b0, 16'd44,    16'h0000, 0, 1'b0, 16'h4444};
    vecs[7]  = '{1'b0, 16'd5,     16'h0000, 4, 1'b0, 16'h1234};
    vecs[8]  = '{1'b1, 16'd7,     16'h0707, 0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 16'd65535, 16'hFFFF, 0, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 16'd7,     16'h0000, 3, 1'b0, 16'h0707};
    vecs[11] = '{1'b1, 16'd255,   16'hABCD, 0, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 16'd255,   16'h0000, 0, 1'b0, 16'hABCD};
    vecs[13] = '{1'b0, 16'd256,   16'h0000, 0, 1'b1, 16'h0000};

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({busy, req_ready, resp_valid, resp_err, resp_rdata}),
          32'({4'b0100, 16'h0}));
    check("reset_outputs_l1", 32'({busy1, req_ready1, resp_valid1, resp_err1, resp_rdata1}),
          32'({4'b0100, 16'h0}));
    rst = 1'b0;

    // Give every word a known value.
    for (int a = 0; a < Depth; a++) model_txn(1'b1, 16'(a), 16'($urandom), 0);

    // Directed vectors.
    for (int v = 0; v < 14; v++) begin
      do_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].delay, vecs[v].exp_err,
             vecs[v].exp_rdata);
      if (vecs[v].we && !vecs[v].exp_err) model[vecs[v].addr[7:0]] = vecs[v].wdata;
    end

    // Reset mid-WAIT drops a pending store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd7; req_wdata = 16'hBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 check("async_reset", 32'({busy, req_ready, resp_valid, resp_err, resp_rdata}),
             32'({4'b0100, 16'h0}));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_txn(1'b0, 16'd7, 16'h0, 0, 1'b0, 16'h0707);

    // Continuous req_valid with changing addresses; only idle-edge requests are taken.
    begin
      int          bl;
      int          accepted;
      int          seen;
      logic [15:0] pend;
      bl = 0; accepted = 0; seen = 0; pend = '0;
      resp_ready = 1'b1;
      for (int n = 0; n < 24; n++) begin
        @(negedge clk);
        check("stream_ready", 32'(req_ready), 32'(bl == 0));
        check("stream_valid", 32'(resp_valid), 32'(bl == 1));
        if (resp_valid) seen++;
        if (bl == 1) check("stream_rdata", 32'(resp_rdata), 32'(model[pend[7:0]]));
        req_valid = (n < 20);
        req_addr  = 16'(100 + n);
        req_we    = (bl != 0);
        req_wdata = 16'($urandom);
        if (bl == 0 && n < 20) begin
          pend = 16'(100 + n);
          accepted++;
          bl = Lat + 1;
        end else if (bl != 0) begin
          bl--;
        end
      end
      check("stream_count", 32'(seen), 32'(accepted));
      req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
    end

    // LATENCY=1 instance: store then load of address 0.
    for (int op = 0; op < 2; op++) begin
      @(negedge clk);
      req_valid1 = 1'b1; req_we1 = (op == 0); req_addr1 = 16'd0; req_wdata1 = 16'h0F0F;
      resp_ready1 = 1'b1;
      @(posedge clk);
      #1 req_valid1 = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("l1_busy", 32'(busy1), 32'(c < 2));
        check("l1_valid", 32'(resp_valid1), 32'(c == 1));
        if (c == 1) check("l1_rdata", 32'(resp_rdata1), (op == 0) ? 32'h0 : 32'h0F0F);
      end
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 150; k++) begin
      logic        we;
      logic [15:0] a;
      we = 1'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(256, 65535));
      else a = 16'($urandom_range(0, 255));
      model_txn(we, a, 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
